// File: rtl/vxe_axi_wr_master_if.sv
// Bus bundle between the VxE switch BIU write queue, the write master and the AXI slave.
// The master modport is the write-master side; slave is the switch/AXI environment.
interface vxe_axi_wr_master_if;

  // switch write queue head and B return path
  logic        biu_awvalid;
  logic [5:0]  biu_awcid;
  logic [39:0] biu_awaddr;
  logic [63:0] biu_awdata;
  logic [7:0]  biu_awstrb;
  logic        biu_awpop;
  logic [5:0]  biu_bcid;
  logic [1:0]  biu_bresp;
  logic        biu_bpush;
  logic        biu_bready;

  // AXI4 AW channel
  logic [5:0]  m_awid;
  logic [39:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid;
  logic        m_awready;

  // AXI4 W channel
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready;

  // AXI4 B channel
  logic [5:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;

  modport master (
    input  biu_awvalid, biu_awcid, biu_awaddr, biu_awdata, biu_awstrb, biu_bready,
    output biu_awpop, biu_bcid, biu_bresp, biu_bpush,
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bid, m_bresp, m_bvalid,
    output m_bready
  );

  modport slave (
    output biu_awvalid, biu_awcid, biu_awaddr, biu_awdata, biu_awstrb, biu_bready,
    input  biu_awpop, biu_bcid, biu_bresp, biu_bpush,
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bid, m_bresp, m_bvalid,
    input  m_bready
  );

endinterface

// File: rtl/vxe_axi_wr_master.sv
// Single-beat AXI4 write master behind the VxE switch: pops BIU write entries, issues AW/W,
// returns B responses through a 1-entry register and bounds in-flight writes.
module vxe_axi_wr_master #(
  parameter int unsigned MAX_OUTST = 16,
  localparam int unsigned CW = $clog2(MAX_OUTST + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  vxe_axi_wr_master_if.master     bus,
  output logic [CW-1:0]           o_outst,
  output logic                    o_err_unexp
);

  localparam int unsigned IDW   = 6;
  localparam int unsigned ADW   = 40;
  localparam int unsigned DW    = 64;
  localparam int unsigned SW    = 8;
  localparam int unsigned RW    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state;
  logic             aw_pend;
  logic             w_pend;
  logic [IDW-1:0]   id_q;
  logic [ADW-1:0]   addr_q;
  logic [DW-1:0]    data_q;
  logic [SW-1:0]    strb_q;

  logic             b_vld;
  logic [IDW-1:0]   bid_q;
  logic [RW-1:0]    bresp_q;

  logic [CW-1:0]    outst;
  logic             err_q;

  logic             aw_done_c;
  logic             w_done_c;
  logic             done_c;
  logic             b_hs_c;
  logic             room_c;
  logic             can_pop_c;

  // Pop decision: a new entry may follow in the cycle the current write finishes.
  // The B handshake frees a slot in the same cycle, so a full counter can still pop then.
  always_comb begin
    aw_done_c = ~aw_pend | bus.m_awready;
    w_done_c  = ~w_pend  | bus.m_wready;
    done_c    = (state == SEND) & aw_done_c & w_done_c;
    b_hs_c    = bus.m_bvalid & bus.m_bready;
    room_c    = (outst < CW'(MAX_OUTST)) | b_hs_c;
    can_pop_c = ~rst & bus.biu_awvalid & room_c & ((state == IDLE) | done_c);
  end

  // Issue FSM: holding registers and independent AW/W pending flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else if (can_pop_c) begin
      state   <= SEND;
      aw_pend <= 1'b1;
      w_pend  <= 1'b1;
      id_q    <= bus.biu_awcid;
      addr_q  <= bus.biu_awaddr;
      data_q  <= bus.biu_awdata;
      strb_q  <= bus.biu_awstrb;
    end else begin
      if (done_c) begin
        state <= IDLE;
      end
      if (bus.m_awready) begin
        aw_pend <= 1'b0;
      end
      if (bus.m_wready) begin
        w_pend <= 1'b0;
      end
    end
  end

  // Outstanding counter; a B with nothing in flight leaves it at zero and flags the error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst <= '0;
      err_q <= 1'b0;
    end else begin
      unique case ({can_pop_c, b_hs_c})
        2'b10: begin
          if (outst != CW'(MAX_OUTST)) begin
            outst <= outst + CW'(1);
          end
        end
        2'b01: begin
          if (outst != '0) begin
            outst <= outst - CW'(1);
          end else begin
            err_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // One-entry B return register; unload and reload in the same cycle keeps it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_vld   <= 1'b0;
      bid_q   <= '0;
      bresp_q <= '0;
    end else if (b_hs_c) begin
      b_vld   <= 1'b1;
      bid_q   <= bus.m_bid;
      bresp_q <= bus.m_bresp;
    end else if (bus.biu_bready) begin
      b_vld   <= 1'b0;
    end
  end

  assign bus.biu_awpop = can_pop_c;

  assign bus.m_awid    = id_q;
  assign bus.m_awaddr  = addr_q;
  assign bus.m_awlen   = 8'd0;
  assign bus.m_awsize  = 3'd3;
  assign bus.m_awburst = 2'b01;
  assign bus.m_awvalid = aw_pend;

  assign bus.m_wdata   = data_q;
  assign bus.m_wstrb   = strb_q;
  assign bus.m_wlast   = 1'b1;
  assign bus.m_wvalid  = w_pend;

  assign bus.m_bready  = ~b_vld | bus.biu_bready;
  assign bus.biu_bpush = b_vld & bus.biu_bready;
  assign bus.biu_bcid  = bid_q;
  assign bus.biu_bresp = bresp_q;

  assign o_outst       = outst;
  assign o_err_unexp   = err_q;

endmodule

// File: tb/tb_vxe_axi_wr_master.sv
// Bench for vxe_axi_wr_master: BIU queue + AXI slave models with AW/W/B scoreboards,
// a table of single-write vectors and hand-written multi-cycle sequences.
module tb_vxe_axi_wr_master;

  localparam int MAX_OUTST = 16;
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic [5:0]  cid;
    logic [39:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } req_t;

  typedef struct packed {
    logic [5:0] id;
    logic [1:0] resp;
  } rsp_t;

  typedef struct {
    req_t       req;
    int         aw_dly;
    int         w_dly;
    logic [1:0] resp;
    int         exp_cyc;
    logic [5:0] exp_bcid;
    logic [1:0] exp_bresp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] o_outst;
  logic          o_err_unexp;

  vxe_axi_wr_master_if bus ();

  vxe_axi_wr_master #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_outst     (o_outst),
    .o_err_unexp (o_err_unexp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  req_t       biu_q[$];
  req_t       aw_exp[$];
  req_t       w_exp[$];
  rsp_t       b_src[$];
  rsp_t       b_exp[$];
  logic [5:0] issued[$];

  logic k_awready = 1'b1;
  logic k_wready  = 1'b1;
  logic k_bready  = 1'b1;

  int   m_outst = 0;
  logic m_err   = 1'b0;
  int   npop    = 0;

  logic ob_pop, ob_awv, ob_wv, ob_aw_hs, ob_w_hs, ob_b_hs, ob_bpush, ob_mbready;
  logic [5:0] ob_bcid;
  logic [1:0] ob_bresp;

  logic        prev_aw_stall = 1'b0;
  logic        prev_w_stall  = 1'b0;
  logic [39:0] prev_awaddr;
  logic [63:0] prev_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk_req(input int j);
    req_t r;
    r.cid  = 6'(j + 1);
    r.addr = 40'h20_0000_0000 + (40'(j) << 3);
    r.data = {32'(j), 32'hC0DE_0000 ^ 32'(j)};
    r.strb = 8'(j) | 8'h01;
    return r;
  endfunction

  function automatic vec_t mk_vec(input logic [5:0] cid, input logic [39:0] addr,
                                  input logic [63:0] data, input logic [7:0] strb,
                                  input int awd, input int wd, input logic [1:0] resp,
                                  input int ec, input logic [5:0] ebcid, input logic [1:0] ebresp);
    vec_t v;
    v.req.cid  = cid;
    v.req.addr = addr;
    v.req.data = data;
    v.req.strb = strb;
    v.aw_dly   = awd;
    v.w_dly    = wd;
    v.resp     = resp;
    v.exp_cyc  = ec;
    v.exp_bcid = ebcid;
    v.exp_bresp = ebresp;
    return v;
  endfunction

  // One clock: drive models at posedge+1, observe/score at posedge+5, advance models after the edge.
  task automatic cycle();
    req_t h;
    req_t e;
    rsp_t b;
    rsp_t eb;
    h = (biu_q.size() != 0) ? biu_q[0] : '0;
    b = (b_src.size() != 0) ? b_src[0] : '0;
    bus.biu_awvalid = (biu_q.size() != 0);
    bus.biu_awcid   = h.cid;
    bus.biu_awaddr  = h.addr;
    bus.biu_awdata  = h.data;
    bus.biu_awstrb  = h.strb;
    bus.biu_bready  = k_bready;
    bus.m_awready   = k_awready;
    bus.m_wready    = k_wready;
    bus.m_bvalid    = (b_src.size() != 0);
    bus.m_bid       = b.id;
    bus.m_bresp     = b.resp;
    #4;
    ob_pop     = bus.biu_awpop;
    ob_awv     = bus.m_awvalid;
    ob_wv      = bus.m_wvalid;
    ob_aw_hs   = bus.m_awvalid & bus.m_awready;
    ob_w_hs    = bus.m_wvalid & bus.m_wready;
    ob_b_hs    = bus.m_bvalid & bus.m_bready;
    ob_bpush   = bus.biu_bpush;
    ob_mbready = bus.m_bready;
    ob_bcid    = bus.biu_bcid;
    ob_bresp   = bus.biu_bresp;

    chk("outst", 64'(o_outst), 64'(m_outst));
    chk("err_unexp", 64'(o_err_unexp), 64'(m_err));

    if (prev_aw_stall) begin
      chk("awvalid_hold", 64'(ob_awv), 64'd1);
      chk("awaddr_hold", 64'(bus.m_awaddr), 64'(prev_awaddr));
    end
    if (prev_w_stall) begin
      chk("wvalid_hold", 64'(ob_wv), 64'd1);
      chk("wdata_hold", bus.m_wdata, prev_wdata);
    end
    prev_aw_stall = ob_awv & ~bus.m_awready;
    prev_w_stall  = ob_wv & ~bus.m_wready;
    prev_awaddr   = bus.m_awaddr;
    prev_wdata    = bus.m_wdata;

    if (ob_aw_hs) begin
      chk("aw_expected", 64'(aw_exp.size() != 0), 64'd1);
      if (aw_exp.size() != 0) begin
        e = aw_exp.pop_front();
        chk("awid", 64'(bus.m_awid), 64'(e.cid));
        chk("awaddr", 64'(bus.m_awaddr), 64'(e.addr));
        chk("awlen", 64'(bus.m_awlen), 64'd0);
        chk("awsize", 64'(bus.m_awsize), 64'd3);
        chk("awburst", 64'(bus.m_awburst), 64'd1);
        issued.push_back(bus.m_awid);
      end
    end
    if (ob_w_hs) begin
      chk("w_expected", 64'(w_exp.size() != 0), 64'd1);
      if (w_exp.size() != 0) begin
        e = w_exp.pop_front();
        chk("wdata", bus.m_wdata, e.data);
        chk("wstrb", 64'(bus.m_wstrb), 64'(e.strb));
        chk("wlast", 64'(bus.m_wlast), 64'd1);
      end
    end
    if (ob_pop) begin
      chk("pop_room", 64'((m_outst < MAX_OUTST) || ob_b_hs), 64'd1);
      chk("pop_aw_clear", 64'(aw_exp.size()), 64'd0);
      chk("pop_w_clear", 64'(w_exp.size()), 64'd0);
      aw_exp.push_back(h);
      w_exp.push_back(h);
    end
    if (ob_bpush) begin
      chk("b_expected", 64'(b_exp.size() != 0), 64'd1);
      if (b_exp.size() != 0) begin
        eb = b_exp.pop_front();
        chk("bcid", 64'(ob_bcid), 64'(eb.id));
        chk("bresp", 64'(ob_bresp), 64'(eb.resp));
      end
    end

    @(posedge clk);
    #1;
    if (ob_pop) begin
      e = biu_q.pop_front();
      npop++;
    end
    if (ob_b_hs) begin
      eb = b_src.pop_front();
      b_exp.push_back(eb);
    end
    if (ob_pop && !ob_b_hs) begin
      if (m_outst < MAX_OUTST) m_outst++;
    end else if (ob_b_hs && !ob_pop) begin
      if (m_outst > 0) m_outst--;
      else m_err = 1'b1;
    end
  endtask

  // Run until every queued write is issued and answered, feeding OKAY responses.
  task automatic drain(input string tag);
    int n;
    n = 0;
    k_awready = 1'b1;
    k_wready  = 1'b1;
    k_bready  = 1'b1;
    while ((biu_q.size() != 0 || m_outst != 0 || b_exp.size() != 0 || b_src.size() != 0 ||
            aw_exp.size() != 0 || w_exp.size() != 0) && n < 300) begin
      if (b_src.size() == 0 && issued.size() != 0) begin
        b_src.push_back(rsp_t'({issued.pop_front(), 2'b00}));
      end
      cycle();
      n++;
    end
    chk({tag, "_drained"}, 64'(n < 300), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[5];
    int         cyc;
    int         hs_at;
    int         npop0;
    logic       aw_seen;
    logic       w_seen;
    logic       got;
    logic [5:0] id0;
    logic [5:0] id1;
    logic [11:0] pop_hist;
    logic [11:0] awv_hist;

    vt[0] = mk_vec(6'd5,  40'h10_0000_0008, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 0, 0, 2'b00, 1, 6'd5,  2'b00);
    vt[1] = mk_vec(6'd3,  40'h00_0000_1000, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, 4, 2'b00, 5, 6'd3,  2'b00);
    vt[2] = mk_vec(6'd9,  40'hFF_FFFF_FFF8, 64'hFFFF_0000_FFFF_0000, 8'h3C, 3, 0, 2'b11, 4, 6'd9,  2'b11);
    vt[3] = mk_vec(6'h3F, 40'h80_0000_0040, 64'hDEAD_BEEF_CAFE_F00D, 8'h81, 2, 2, 2'b10, 3, 6'h3F, 2'b10);
    vt[4] = mk_vec(6'h2A, 40'h00_0000_0000, 64'h0000_0000_0000_0001, 8'h0F, 1, 2, 2'b01, 3, 6'h2A, 2'b01);

    // reset state, with a pending queue entry that must not be popped
    rst = 1'b1;
    bus.biu_awvalid = 1'b1;
    bus.biu_awcid   = 6'd1;
    bus.biu_awaddr  = 40'h8;
    bus.biu_awdata  = 64'h1;
    bus.biu_awstrb  = 8'hFF;
    bus.biu_bready  = 1'b1;
    bus.m_awready   = 1'b1;
    bus.m_wready    = 1'b1;
    bus.m_bvalid    = 1'b0;
    bus.m_bid       = 6'd0;
    bus.m_bresp     = 2'b00;
    #12;
    chk("rst_awpop", 64'(bus.biu_awpop), 64'd0);
    chk("rst_awvalid", 64'(bus.m_awvalid), 64'd0);
    chk("rst_wvalid", 64'(bus.m_wvalid), 64'd0);
    chk("rst_bready", 64'(bus.m_bready), 64'd1);
    chk("rst_bpush", 64'(bus.biu_bpush), 64'd0);
    chk("rst_outst", 64'(o_outst), 64'd0);
    chk("rst_err", 64'(o_err_unexp), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // table-driven single writes with AW/W ready delays
    for (int i = 0; i < 5; i++) begin
      biu_q.push_back(vt[i].req);
      k_awready = 1'b1;
      k_wready  = 1'b1;
      k_bready  = 1'b1;
      cycle();
      chk("v_pop_c0", 64'(ob_pop), 64'd1);
      cyc = 0;
      aw_seen = 1'b0;
      w_seen  = 1'b0;
      while (!(aw_seen && w_seen) && cyc < 20) begin
        k_awready = (cyc >= vt[i].aw_dly);
        k_wready  = (cyc >= vt[i].w_dly);
        cycle();
        if (cyc == 0) begin
          chk("v_awvalid_c1", 64'(ob_awv), 64'd1);
          chk("v_wvalid_c1", 64'(ob_wv), 64'd1);
        end
        aw_seen = aw_seen | ob_aw_hs;
        w_seen  = w_seen | ob_w_hs;
        cyc++;
      end
      chk("v_done_cycles", 64'(cyc), 64'(vt[i].exp_cyc));
      chk("v_outst_1", 64'(o_outst), 64'd1);
      if (issued.size() != 0) id0 = issued.pop_front();
      b_src.push_back(rsp_t'({vt[i].req.cid, vt[i].resp}));
      cyc = 0;
      hs_at = -1;
      got = 1'b0;
      while (!got && cyc < 10) begin
        cycle();
        if (ob_b_hs) hs_at = cyc;
        if (ob_bpush) begin
          got = 1'b1;
          chk("v_bcid", 64'(ob_bcid), 64'(vt[i].exp_bcid));
          chk("v_bresp", 64'(ob_bresp), 64'(vt[i].exp_bresp));
          chk("v_bpush_lat", 64'(cyc - hs_at), 64'd1);
        end
        cyc++;
      end
      chk("v_bpush_seen", 64'(got), 64'd1);
      cycle();
      chk("v_outst_0", 64'(o_outst), 64'd0);
    end

    // W held off four cycles: AW completes alone, next entry waits for W
    biu_q.push_back(mk_req(50));
    biu_q.push_back(mk_req(51));
    k_awready = 1'b1;
    k_wready  = 1'b0;
    cycle();
    chk("t2_pop_c0", 64'(ob_pop), 64'd1);
    for (int j = 0; j < 4; j++) begin
      cycle();
      if (j == 0) chk("t2_aw_c1", 64'(ob_aw_hs), 64'd1);
      chk("t2_no_pop", 64'(ob_pop), 64'd0);
      chk("t2_wvalid_held", 64'(ob_wv), 64'd1);
    end
    k_wready = 1'b1;
    cycle();
    chk("t2_w_hs", 64'(ob_w_hs), 64'd1);
    chk("t2_pop_on_done", 64'(ob_pop), 64'd1);
    drain("t2");

    // throttle at MAX_OUTST with no responses
    for (int j = 0; j < 20; j++) biu_q.push_back(mk_req(j));
    npop0 = npop;
    for (int j = 0; j < 24; j++) begin
      cycle();
      if (j >= 16) chk("t3_no_pop_full", 64'(ob_pop), 64'd0);
    end
    chk("t3_pops", 64'(npop - npop0), 64'd16);
    chk("t3_outst_full", 64'(o_outst), 64'd16);
    b_src.push_back(rsp_t'({issued.pop_front(), 2'b00}));
    cycle();
    chk("t3_b_hs", 64'(ob_b_hs), 64'd1);
    chk("t3_pop_with_b", 64'(ob_pop), 64'd1);
    cycle();
    chk("t3_outst_still_full", 64'(o_outst), 64'd16);
    chk("t3_no_pop_after", 64'(ob_pop), 64'd0);
    drain("t3");

    // streaming: eight back-to-back writes
    for (int j = 0; j < 8; j++) biu_q.push_back(mk_req(100 + j));
    pop_hist = '0;
    awv_hist = '0;
    for (int j = 0; j < 12; j++) begin
      cycle();
      pop_hist[j] = ob_pop;
      awv_hist[j] = ob_awv;
    end
    chk("t4_pop_pattern", 64'(pop_hist), 64'h0FF);
    chk("t4_awv_pattern", 64'(awv_hist), 64'h1FE);
    chk("t4_outst", 64'(o_outst), 64'd8);
    drain("t4");

    // B backpressure from the switch
    biu_q.push_back(mk_req(200));
    biu_q.push_back(mk_req(201));
    for (int j = 0; j < 3; j++) cycle();
    chk("t5_outst", 64'(o_outst), 64'd2);
    k_bready = 1'b0;
    id0 = issued.pop_front();
    id1 = issued.pop_front();
    b_src.push_back(rsp_t'({id0, 2'b00}));
    b_src.push_back(rsp_t'({id1, 2'b01}));
    cycle();
    chk("t5_first_hs", 64'(ob_b_hs), 64'd1);
    chk("t5_no_push_yet", 64'(ob_bpush), 64'd0);
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk("t5_bready_low", 64'(ob_mbready), 64'd0);
      chk("t5_no_bpush", 64'(ob_bpush), 64'd0);
    end
    k_bready = 1'b1;
    cycle();
    chk("t5_push1", 64'(ob_bpush), 64'd1);
    chk("t5_id1", 64'(ob_bcid), 64'(id0));
    chk("t5_second_hs", 64'(ob_b_hs), 64'd1);
    cycle();
    chk("t5_push2", 64'(ob_bpush), 64'd1);
    chk("t5_id2", 64'(ob_bcid), 64'(id1));
    chk("t5_resp2", 64'(ob_bresp), 64'd1);
    cycle();
    chk("t5_outst0", 64'(o_outst), 64'd0);
    chk("t5_no_extra_push", 64'(ob_bpush), 64'd0);

    // unexpected B with nothing outstanding, SLVERR passthrough
    b_src.push_back(rsp_t'({6'd7, 2'b10}));
    cycle();
    chk("t6_b_hs", 64'(ob_b_hs), 64'd1);
    cycle();
    chk("t6_bpush", 64'(ob_bpush), 64'd1);
    chk("t6_bcid", 64'(ob_bcid), 64'd7);
    chk("t6_bresp", 64'(ob_bresp), 64'd2);
    chk("t6_err", 64'(o_err_unexp), 64'd1);
    chk("t6_outst_zero", 64'(o_outst), 64'd0);
    for (int j = 0; j < 3; j++) cycle();
    chk("t6_err_sticky", 64'(o_err_unexp), 64'd1);

    // reset asserted mid-SEND with a captured B response
    k_awready = 1'b0;
    k_wready  = 1'b0;
    k_bready  = 1'b0;
    biu_q.push_back(mk_req(300));
    biu_q.push_back(mk_req(301));
    cycle();
    chk("t6_pop", 64'(ob_pop), 64'd1);
    b_src.push_back(rsp_t'({6'd12, 2'b00}));
    cycle();
    chk("t6_send_awv", 64'(ob_awv), 64'd1);
    cycle();
    chk("t6_b_held", 64'(ob_mbready), 64'd0);
    bus.biu_bready = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_rst_awvalid", 64'(bus.m_awvalid), 64'd0);
    chk("t6_rst_wvalid", 64'(bus.m_wvalid), 64'd0);
    chk("t6_rst_awpop", 64'(bus.biu_awpop), 64'd0);
    chk("t6_rst_bready", 64'(bus.m_bready), 64'd1);
    chk("t6_rst_bpush", 64'(bus.biu_bpush), 64'd0);
    chk("t6_rst_outst", 64'(o_outst), 64'd0);
    chk("t6_rst_err", 64'(o_err_unexp), 64'd0);
    biu_q.delete();
    aw_exp.delete();
    w_exp.delete();
    b_src.delete();
    b_exp.delete();
    issued.delete();
    m_outst = 0;
    m_err = 1'b0;
    prev_aw_stall = 1'b0;
    prev_w_stall = 1'b0;
    k_awready = 1'b1;
    k_wready  = 1'b1;
    k_bready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    chk("t6_post_rst_idle", 64'(ob_awv), 64'd0);
    biu_q.push_back(mk_req(400));
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
